// File: rtl/ovc_credit_status_pkg.sv
// Shared NoC definitions for output-VC credit/ownership tracking.
package ovc_credit_status_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } ovc_state_t;

  localparam string REALLOC_ATOMIC    = "ATOMIC";
  localparam string REALLOC_NONATOMIC = "NONATOMIC";

  // Smallest r with 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/ovc_credit_slot.sv
// One output VC: downstream credit counter, ownership FSM and per-cycle error pulse.
module ovc_credit_slot
  import ovc_credit_status_pkg::*;
#(
  parameter int B      = 4,
  parameter int CW     = 3,
  parameter bit ATOMIC = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_alloc,
  input  logic          i_sent,
  input  logic          i_tail,
  input  logic          i_credit,
  output logic          o_avail,
  output logic          o_full,
  output logic          o_nearly_full,
  output logic [CW-1:0] o_cnt,
  output logic          o_err
);

  localparam logic [CW-1:0] BMAX = CW'(B);

  logic [CW-1:0] r_cnt;
  ovc_state_t    r_state;
  ovc_state_t    w_state_nxt;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_udf, w_ovf, w_tail;

  always_comb begin
    w_sum = {1'b0, r_cnt} + {{CW{1'b0}}, i_credit} - {{CW{1'b0}}, i_sent};
    w_udf = i_sent & ~i_credit & (r_cnt == '0);
    w_ovf = i_credit & ~i_sent & (r_cnt == BMAX);
    if (w_udf)      w_cnt_nxt = '0;
    else if (w_ovf) w_cnt_nxt = BMAX;
    else            w_cnt_nxt = w_sum[CW-1:0];
  end

  // A tail only counts when a flit actually leaves with it.
  assign w_tail = i_tail & i_sent;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_alloc) w_state_nxt = w_tail ? (ATOMIC ? DRAIN : IDLE) : BUSY;
      BUSY:    if (w_tail)  w_state_nxt = ATOMIC ? DRAIN : IDLE;
      default: ;
    endcase
    // Drain completes as soon as every credit is back, including on entry.
    if (w_state_nxt == DRAIN && w_cnt_nxt == BMAX) w_state_nxt = IDLE;
  end

  assign o_err = (i_alloc & (r_state != IDLE))
               | (i_tail & ~i_sent)
               | (i_sent & ~i_alloc & (r_state == IDLE))
               | w_udf | w_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= BMAX;
      r_state <= IDLE;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign o_avail       = (r_state == IDLE);
  assign o_full        = (r_cnt == '0);
  assign o_nearly_full = (r_cnt <= CW'(1));
  assign o_cnt         = r_cnt;

endmodule

// File: rtl/ovc_credit_status.sv
// Router-wide OVC ownership/credit tracker: P*V slots plus sticky per-port error flags.
module ovc_credit_status
  import ovc_credit_status_pkg::*;
#(
  parameter int    P               = 5,
  parameter int    V               = 4,
  parameter int    B               = 4,
  parameter string VC_REALLOC_TYPE = "NONATOMIC",
  localparam int   CW              = clog2(B + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [P*V-1:0]    ovc_alloc_all,
  input  logic [P*V-1:0]    flit_sent_all,
  input  logic [P*V-1:0]    tail_sent_all,
  input  logic [P*V-1:0]    credit_in_all,
  output logic [P*V-1:0]    ovc_avail_all,
  output logic [P*V-1:0]    ovc_full_all,
  output logic [P*V-1:0]    ovc_nearly_full_all,
  output logic [P*V*CW-1:0] credit_cnt_all,
  output logic [P-1:0]      err_all
);

  localparam bit ATOMIC = (VC_REALLOC_TYPE == REALLOC_ATOMIC);

  logic [P-1:0][V-1:0] w_err_pulse;
  logic [P-1:0]        w_port_err;
  logic [P-1:0]        r_err;

  for (genvar i = 0; i < P*V; i++) begin : g_slot
    ovc_credit_slot #(.B(B), .CW(CW), .ATOMIC(ATOMIC)) u_slot (
      .clk          (clk),
      .rst_n        (reset),
      .i_alloc      (ovc_alloc_all[i]),
      .i_sent       (flit_sent_all[i]),
      .i_tail       (tail_sent_all[i]),
      .i_credit     (credit_in_all[i]),
      .o_avail      (ovc_avail_all[i]),
      .o_full       (ovc_full_all[i]),
      .o_nearly_full(ovc_nearly_full_all[i]),
      .o_cnt        (credit_cnt_all[i*CW +: CW]),
      .o_err        (w_err_pulse[i/V][i%V])
    );
  end

  for (genvar p = 0; p < P; p++) begin : g_port
    assign w_port_err[p] = |w_err_pulse[p];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= '0;
    else        r_err <= r_err | w_port_err;
  end

  assign err_all = r_err;

endmodule

// File: tb/tb_ovc_credit_status.sv
// Bench for ovc_credit_status: one NONATOMIC and one ATOMIC instance, directed table + random vs model.
module tb_ovc_credit_status;

  localparam int P  = 5;
  localparam int V  = 4;
  localparam int B  = 4;
  localparam int CW = 3;
  localparam int N  = P*V;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0]    al[2], se[2], ta[2], cr[2];
  logic [N-1:0]    av[2], fu[2], nf[2];
  logic [N*CW-1:0] cn[2];
  logic [P-1:0]    er[2];

  always #5 clk = ~clk;

  ovc_credit_status #(.P(P), .V(V), .B(B), .VC_REALLOC_TYPE("NONATOMIC")) dut_n (
    .clk(clk), .reset(reset),
    .ovc_alloc_all(al[0]), .flit_sent_all(se[0]), .tail_sent_all(ta[0]), .credit_in_all(cr[0]),
    .ovc_avail_all(av[0]), .ovc_full_all(fu[0]), .ovc_nearly_full_all(nf[0]),
    .credit_cnt_all(cn[0]), .err_all(er[0]));

  ovc_credit_status #(.P(P), .V(V), .B(B), .VC_REALLOC_TYPE("ATOMIC")) dut_a (
    .clk(clk), .reset(reset),
    .ovc_alloc_all(al[1]), .flit_sent_all(se[1]), .tail_sent_all(ta[1]), .credit_in_all(cr[1]),
    .ovc_avail_all(av[1]), .ovc_full_all(fu[1]), .ovc_nearly_full_all(nf[1]),
    .credit_cnt_all(cn[1]), .err_all(er[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      al[d] = '0; se[d] = '0; ta[d] = '0; cr[d] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drive(input int d, input int i, input logic a, input logic s, input logic t, input logic c);
    al[d][i] = a; se[d][i] = s; ta[d][i] = t; cr[d][i] = c;
  endtask

  task automatic chk_ovc(input string nm, input int d, input int i,
                         input logic exp_av, input int exp_cnt, input logic exp_err);
    logic [CW-1:0] c;
    c = cn[d][i*CW +: CW];
    chk({nm, ".avail"}, av[d][i], exp_av);
    chk({nm, ".cnt"},   c, exp_cnt);
    chk({nm, ".full"},  fu[d][i], exp_cnt == 0);
    chk({nm, ".nfull"}, nf[d][i], exp_cnt <= 1);
    chk({nm, ".err"},   er[d][i/V], exp_err);
  endtask

  task automatic chk_reset_state(input string nm);
    logic [N*CW-1:0] all4;
    for (int i = 0; i < N; i++) all4[i*CW +: CW] = 3'(B);
    for (int d = 0; d < 2; d++) begin
      chk({nm, ".avail"}, av[d], {N{1'b1}});
      chk({nm, ".full"},  fu[d], '0);
      chk({nm, ".nfull"}, nf[d], '0);
      chk({nm, ".cnt"},   cn[d], all4);
      chk({nm, ".err"},   er[d], '0);
    end
  endtask

  // ---------------- behavioural model for random phase ----------------
  int mcnt[2][N];
  int mst[2][N];      // 0 free, 1 owned by a packet, 2 waiting for credits
  bit merr[2][P];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin mcnt[d][i] = B; mst[d][i] = 0; end
      for (int p = 0; p < P; p++) merr[d][p] = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    for (int i = 0; i < N; i++) begin
      int n, st, ns;
      bit a, s, t, c, e, tl;
      a = al[d][i]; s = se[d][i]; t = ta[d][i]; c = cr[d][i];
      st = mst[d][i];
      e = 1'b0;
      n = mcnt[d][i] - int'(s) + int'(c);
      if (n < 0) begin n = 0; e = 1'b1; end
      if (n > B) begin n = B; e = 1'b1; end
      if (a && st != 0)       e = 1'b1;
      if (t && !s)            e = 1'b1;
      if (s && !a && st == 0) e = 1'b1;
      tl = t && s;
      ns = st;
      if (st == 0 && a)       ns = tl ? (d == 1 ? 2 : 0) : 1;
      else if (st == 1 && tl) ns = (d == 1) ? 2 : 0;
      if (ns == 2 && n == B)  ns = 0;
      mcnt[d][i] = n;
      mst[d][i]  = ns;
      if (e) merr[d][i/V] = 1'b1;
    end
  endtask

  task automatic model_check(input int d, input int cyc);
    logic [N-1:0]    e_av, e_fu, e_nf;
    logic [N*CW-1:0] e_cn;
    logic [P-1:0]    e_er;
    string tag;
    for (int i = 0; i < N; i++) begin
      e_av[i] = (mst[d][i] == 0);
      e_fu[i] = (mcnt[d][i] == 0);
      e_nf[i] = (mcnt[d][i] <= 1);
      e_cn[i*CW +: CW] = 3'(mcnt[d][i]);
    end
    for (int p = 0; p < P; p++) e_er[p] = merr[d][p];
    tag = $sformatf("rnd[d%0d c%0d]", d, cyc);
    chk({tag, ".avail"}, av[d], e_av);
    chk({tag, ".full"},  fu[d], e_fu);
    chk({tag, ".nfull"}, nf[d], e_nf);
    chk({tag, ".cnt"},   cn[d], e_cn);
    chk({tag, ".err"},   er[d], e_er);
  endtask

  typedef struct {
    logic a, s, t, c;
    logic av;
    int   cnt;
    logic err;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // OVC 6 (port 1): header, 4 sends to empty, balanced traffic, protocol errors, tail.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1};

    do_reset();
    chk_reset_state("reset");

    for (int k = 0; k < 16; k++) begin
      drive(0, 6, tbl[k].a, tbl[k].s, tbl[k].t, tbl[k].c);
      tick();
      clr();
      chk_ovc($sformatf("tbl%0d", k), 0, 6, tbl[k].av, tbl[k].cnt, tbl[k].err);
    end
    chk("tbl.ovc7_untouched", av[0][7], 1'b1);

    // NONATOMIC 3-flit packet on OVC 2, immediate re-allocation after tail.
    do_reset();
    drive(0, 2, 1, 1, 0, 0); tick(); clr();
    drive(0, 2, 0, 1, 0, 0); tick(); clr();
    drive(0, 2, 0, 1, 1, 0); tick(); clr();
    chk_ovc("nonatomic.tail", 0, 2, 1'b1, 1, 1'b0);
    drive(0, 2, 1, 0, 0, 0); tick(); clr();
    chk_ovc("nonatomic.realloc", 0, 2, 1'b0, 1, 1'b0);

    // ATOMIC single-flit packet on OVC 0: stays unavailable until its credit returns.
    drive(1, 0, 1, 1, 1, 0); tick(); clr();
    chk_ovc("atomic.t1", 1, 0, 1'b0, 3, 1'b0);
    tick();
    chk_ovc("atomic.t2", 1, 0, 1'b0, 3, 1'b0);
    tick();
    chk_ovc("atomic.t3", 1, 0, 1'b0, 3, 1'b0);
    drive(1, 0, 0, 0, 0, 1); tick(); clr();
    chk_ovc("atomic.t4", 1, 0, 1'b1, 4, 1'b0);

    // Credit overflow on an idle OVC of port 2.
    drive(0, 8, 0, 0, 0, 1); tick(); clr();
    chk_ovc("overflow", 0, 8, 1'b1, 4, 1'b1);

    // Credit underflow on port 3 after draining all credits.
    drive(0, 12, 1, 1, 0, 0); tick(); clr();
    for (int k = 0; k < 3; k++) begin
      drive(0, 12, 0, 1, 0, 0); tick(); clr();
    end
    chk_ovc("underflow.pre", 0, 12, 1'b0, 0, 1'b0);
    drive(0, 12, 0, 1, 0, 0); tick(); clr();
    chk_ovc("underflow", 0, 12, 1'b0, 0, 1'b1);

    // Asynchronous reset while OVC 16 is BUSY with one credit left.
    drive(0, 16, 1, 1, 0, 0); tick(); clr();
    drive(0, 16, 0, 1, 0, 0); tick(); clr();
    drive(0, 16, 0, 1, 0, 0); tick(); clr();
    chk_ovc("async.pre", 0, 16, 1'b0, 1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_ovc("async.reset", 0, 16, 1'b1, 4, 1'b0);
    chk_reset_state("async.all");

    // Random traffic, mostly legal with sparse protocol violations.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          bit a, s, t, c;
          a = (mst[d][i] == 0) && ($urandom % 4 == 0);
          s = (mst[d][i] == 1 || a) && (mcnt[d][i] > 0) && ($urandom % 2 == 0);
          t = s && ($urandom % 3 == 0);
          c = (mcnt[d][i] - int'(s) < B) && ($urandom % 2 == 0);
          if ($urandom % 150 == 0) begin
            case ($urandom % 4)
              0: a = ~a;
              1: s = ~s;
              2: t = ~t;
              default: c = ~c;
            endcase
          end
          drive(d, i, a, s, t, c);
        end
        model_step(d);
      end
      tick();
      clr();
      for (int d = 0; d < 2; d++) model_check(d, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
